// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl - sequential 8x8 unsigned multiplier controller.
//
// A single 4x4 multiplier (i4bit_mul) is time-shared over four CALC steps.
// Each step multiplies one nibble of A by one nibble of B, shifts the
// partial product by its weight and adds it into a 16-bit accumulator.
// The final sum is copied into the product register, which drives
// prod_high/prod_low and holds its value through IDLE until the next
// product is ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   requester presents op_a/op_b
//   in_ready   controller idle and able to accept operands
//   op_a       8-bit unsigned multiplicand
//   op_b       8-bit unsigned multiplier
//   out_valid  product available (DONE)
//   out_ready  consumer takes the product
//   prod_low   product bits [7:0]
//   prod_high  product bits [15:8]
//   busy       high in CALC or DONE
//
// Build option:
//   MUL_SEQ_ZERO_SKIP_EN  when defined, a zero operand skips CALC and goes
//                         straight to DONE with a zero product.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// CALC  | four nibble multiply-accumulate steps, step = 0..3
// DONE  | product presented on out_valid until out_ready

module i4bit_mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = a * b;
endmodule

module mul_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] prod_low,
  output logic [7:0] prod_high,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  a_q, b_q;
  logic [1:0]  step;
  logic [15:0] acc;
  logic [15:0] prod;
  logic        accept;

  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_shift;
  logic [15:0] acc_sum;

  // step bit 0 picks the A nibble, step bit 1 picks the B nibble, which
  // yields the order lo*lo, hi*lo, lo*hi, hi*hi.
  assign nib_a = step[0] ? a_q[7:4] : a_q[3:0];
  assign nib_b = step[1] ? b_q[7:4] : b_q[3:0];

  i4bit_mul u_mul (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  always_comb begin
    pp_shift = {8'h00, pp};
    case (step)
      2'd1, 2'd2: pp_shift = {4'h0, pp, 4'h0};
      2'd3:       pp_shift = {pp, 8'h00};
      default:    pp_shift = {8'h00, pp};
    endcase
  end

  assign acc_sum = acc + pp_shift;
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef MUL_SEQ_ZERO_SKIP_EN
          if ((op_a == 8'h00) || (op_b == 8'h00)) state_nxt = DONE;
          else                                    state_nxt = CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC: begin
        busy = 1'b1;
        if (step == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= 8'h00;
      b_q  <= 8'h00;
      step <= 2'd0;
      acc  <= 16'h0000;
      prod <= 16'h0000;
    end else if (accept) begin
      a_q  <= op_a;
      b_q  <= op_b;
      step <= 2'd0;
      acc  <= 16'h0000;
`ifdef MUL_SEQ_ZERO_SKIP_EN
      // Skipped operations still present a fresh (zero) product in DONE.
      if ((op_a == 8'h00) || (op_b == 8'h00)) prod <= 16'h0000;
`endif
    end else if (state == CALC) begin
      acc  <= acc_sum;
      step <= step + 2'd1;
      if (step == 2'd3) prod <= acc_sum;
    end
  end

  assign prod_low  = prod[7:0];
  assign prod_high = prod[15:8];

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed and random-stream bench for mul_seq_ctrl.
module tb_mul_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] prod_low;
  logic [7:0] prod_high;
  logic       busy;

  int n_vec;
  int n_err;

`ifdef MUL_SEQ_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 4;
`endif

  mul_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_low  (prod_low),
    .prod_high (prod_high),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair while idle, then counts edges after the
  // accept edge until out_valid rises. lat = -1 if it never does.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    lat      = -1;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a     = 8'h00;
    op_b     = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 8'h00;
    op_b      = 8'h00;
    tick();
    tick();
    n_vec++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_flags: got in_ready/out_valid/busy=%b expected 100", {in_ready, out_valid, busy});
    end
    n_vec++;
    if ({prod_high, prod_low} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_prod: got %h expected 0000", {prod_high, prod_low});
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_max();
    int lat;
    out_ready = 1'b1;
    run_op(8'hFF, 8'hFF, lat);
    n_vec++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL max_latency: got %0d expected 4", lat);
    end
    n_vec++;
    if ({prod_high, prod_low} !== 16'hFE01) begin
      n_err++;
      $display("FAIL max_prod: got %h expected fe01", {prod_high, prod_low});
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL max_busy: got %b expected 1", busy);
    end
    tick();
    n_vec++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL max_return_idle: got out_valid/in_ready/busy=%b expected 010", {out_valid, in_ready, busy});
    end
    n_vec++;
    if ({prod_high, prod_low} !== 16'hFE01) begin
      n_err++;
      $display("FAIL max_hold_in_idle: got %h expected fe01", {prod_high, prod_low});
    end
  endtask

  task automatic test_input_change();
    int lat;
    out_ready = 1'b0;
    run_op(8'h12, 8'h34, lat);
    n_vec++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL chg_latency: got %0d expected 4", lat);
    end
    n_vec++;
    if ({prod_high, prod_low} !== 16'h03A8) begin
      n_err++;
      $display("FAIL chg_prod: got %h expected 03a8", {prod_high, prod_low});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL chg_release: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int xfers;
    out_ready = 1'b0;
    run_op(8'h0F, 8'h11, lat);
    n_vec++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL bp_latency: got %0d expected 4", lat);
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      op_a     = 8'h77;
      op_b     = 8'h99;
      tick();
      n_vec++;
      if ({out_valid, in_ready, busy, prod_high, prod_low} !== {3'b101, 16'h00FF}) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got v/r/b=%b prod=%h expected 101 prod=00ff",
                 c, {out_valid, in_ready, busy}, {prod_high, prod_low});
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    xfers = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) xfers++;
      tick();
    end
    n_vec++;
    if (xfers !== 1) begin
      n_err++;
      $display("FAIL bp_single_transfer: got %0d transfers expected 1", xfers);
    end
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_idle: got out_valid/in_ready=%b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    out_ready = 1'b1;
    op_a      = 8'hAB;
    op_b      = 8'hCD;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #2;
    n_vec++;
    if ({in_ready, out_valid, busy, prod_high, prod_low} !== {3'b100, 16'h0000}) begin
      n_err++;
      $display("FAIL rstmid_outputs: got r/v/b=%b prod=%h expected 100 prod=0000",
               {in_ready, out_valid, busy}, {prod_high, prod_low});
    end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL rstmid_no_valid: got %0d valid cycles expected 0", seen);
    end
    run_op(8'h03, 8'h05, lat);
    n_vec++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL rstmid_next_latency: got %0d expected 4", lat);
    end
    n_vec++;
    if ({prod_high, prod_low} !== 16'h000F) begin
      n_err++;
      $display("FAIL rstmid_next_prod: got %h expected 000f", {prod_high, prod_low});
    end
    tick();
  endtask

  task automatic test_zero();
    int lat;
    out_ready = 1'b0;
    run_op(8'h00, 8'hAB, lat);
    n_vec++;
    if (lat !== ZERO_LAT) begin
      n_err++;
      $display("FAIL zero_latency: got %0d expected %0d", lat, ZERO_LAT);
    end
    n_vec++;
    if ({prod_high, prod_low} !== 16'h0000) begin
      n_err++;
      $display("FAIL zero_prod: got %h expected 0000", {prod_high, prod_low});
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    int          got;
    got = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] a;
          logic [7:0] b;
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          op_a     = a;
          op_b     = b;
          in_valid = 1'b1;
          for (int w = 0; w < 200; w++) begin
            if (in_ready) begin
              exp_q.push_back(16'(a) * 16'(b));
              tick();
              break;
            end
            tick();
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 30000 && got < 1000; c++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL stream_extra: got %h with no outstanding request", {prod_high, prod_low});
            end else begin
              exp_v = exp_q.pop_front();
              if ({prod_high, prod_low} !== exp_v) begin
                n_err++;
                $display("FAIL stream_prod_%0d: got %h expected %h", got, {prod_high, prod_low}, exp_v);
              end
            end
            got++;
          end
          tick();
        end
      end
    join
    n_vec++;
    if (got !== 1000 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL stream_count: got %0d products, %0d outstanding; expected 1000, 0", got, exp_q.size());
    end
    out_ready = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_max();
    test_input_change();
    test_backpressure();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameters: none; all widths fixed (8-bit operands, 16-bit product).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  requester presents operands.
REQ-005 in_ready  output  1  controller can accept operands.
REQ-006 op_a  input  8  multiplicand, unsigned.
REQ-007 op_b  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  product available.
REQ-009 out_ready  input  1  consumer takes product.
REQ-010 prod_low  output  8  product bits [7:0].
REQ-011 prod_high  output  8  product bits [15:8].
REQ-012 busy  output  1  high in CALC or DONE.

Function
REQ-013 Shall contain exactly one 4x4 unsigned multiplier instance (i4bit_mul), time-shared over four steps; no wider multiplier inferred.
REQ-014 States: IDLE, CALC, DONE; 2-bit step counter used only in CALC.
REQ-015 Accept = in_valid & in_ready at a rising edge; op_a/op_b latched into internal registers; later input changes ignored until next accept.
REQ-016 in_ready = 1 only in IDLE; in_valid in CALC/DONE ignored, no queuing.
REQ-017 IDLE -> CALC on accept, step counter cleared to 0, 16-bit accumulator cleared to 0.
REQ-018 CALC step order and weighting: step0 A[3:0]*B[3:0] <<0; step1 A[7:4]*B[3:0] <<4; step2 A[3:0]*B[7:4] <<4; step3 A[7:4]*B[7:4] <<8; each partial product zero-extended to 16 bits and added to the accumulator at the end of its step.
REQ-019 Accumulator 16 bits, no overflow possible (max 255*255 = 16'hFE01); no saturation logic.
REQ-020 CALC -> DONE at the edge completing step3; latency: accept at edge T, out_valid high after edge T+4.
REQ-021 In DONE: out_valid = 1, {prod_high, prod_low} = accumulator, held stable while out_ready = 0 (unbounded backpressure).
REQ-022 DONE -> IDLE on out_valid & out_ready; out_valid low and in_ready high after that edge; earliest next accept one cycle later.
REQ-023 prod_low/prod_high hold last product in IDLE until next DONE; undefined values never driven.
REQ-024 Illegal state encodings recover to IDLE on next edge.

Reset
REQ-025 rst asserted at any time (including mid-CALC or DONE) immediately forces IDLE, step counter 0, accumulator 0, operand registers 0.
REQ-026 Reset values: in_ready = 1, out_valid = 0, busy = 0, prod_low = 8'h00, prod_high = 8'h00.
REQ-027 Aborted operation produces no out_valid pulse; first accept possible on first edge after rst deasserts.

Configuration
REQ-028 Macro MUL_SEQ_ZERO_SKIP_EN: when defined, an accept with op_a == 0 or op_b == 0 goes IDLE -> DONE directly with product 16'h0000, out_valid high after edge T+1; multiplier not exercised.
REQ-029 Without MUL_SEQ_ZERO_SKIP_EN, zero operands take the full four-step CALC path (latency T+4, product 0); interface identical in both builds.

Verification
REQ-030 op_a=8'hFF, op_b=8'hFF, out_ready=1 -> out_valid after edge T+4, prod_high=8'hFE, prod_low=8'h01, in_ready high next cycle.
REQ-031 op_a=8'h12, op_b=8'h34 -> product 16'h03A8; op_a/op_b changed to 8'h00 during CALC -> result unchanged.
REQ-032 Backpressure: out_ready=0 for 10 cycles after DONE -> out_valid and product stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> single transfer, return to IDLE.
REQ-033 rst pulsed during step2 of 8'hAB*8'hCD -> all outputs at reset values, no out_valid; next op 8'h03*8'h05 -> 16'h000F at T+4.
REQ-034 op_a=8'h00, op_b=8'hAB -> product 16'h0000; out_valid after T+1 with MUL_SEQ_ZERO_SKIP_EN, after T+4 without.
REQ-035 Random back-to-back stream of 1000 operand pairs with random out_ready -> every product equals op_a*op_b, in order, none dropped or duplicated.
